// File: rtl/multicycle_alu.sv
// multicycle_alu: ALU with a START/DONE handshake, barrel shifts/rotate and an optional shift-add multiplier (ALU_MUL_EN)
module multicycle_alu #(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = $clog2(DATA_W) + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [3:0]        SELECT,
    input  logic [DATA_W-1:0] DATA1,
    input  logic [DATA_W-1:0] DATA2,
    output logic [DATA_W-1:0] RESULT,
    output logic              ZERO,
    output logic              BUSY,
    output logic              DONE,
    output logic              ILLEGAL
);
    localparam logic [3:0] OP_FWD = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [SHAMT_W-1:0] W_SH = SHAMT_W'(DATA_W);
    logic [SHAMT_W-1:0] sh, rot;
    logic [DATA_W-1:0]  sc_res, mul_res, fin_res;
    logic               sc_ill, sc_go, mul_fin, mul_sel, idle;
    assign sh      = DATA2[SHAMT_W-1:0];
    assign rot     = sh % W_SH;
    assign sc_go   = START && idle && !mul_sel;
    assign fin_res = mul_fin ? mul_res : sc_res;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd4;
    typedef enum logic {IDLE, MUL_RUN} state_t;
    state_t             state, state_n;
    logic [DATA_W-1:0]  acc, acc_n, mcand, mplier;
    logic [SHAMT_W-1:0] cnt;
    logic               last;
    assign idle    = state == IDLE;
    assign mul_sel = SELECT == OP_MUL;
    assign last    = cnt == W_SH - 1'b1;
    assign acc_n   = acc + (mplier[0] ? mcand : '0);
    assign mul_fin = state == MUL_RUN && last;
    assign mul_res = acc_n;
    // State register
    always_ff @(posedge CLK) begin
        state <= RESET ? IDLE : state_n;
    end
    // Next state: enter MUL_RUN on an accepted MUL, leave after the last iteration
    always_comb begin
        state_n = state;
        if (idle && START && mul_sel)
            state_n = MUL_RUN;
        else if (mul_fin)
            state_n = IDLE;
    end
    // Multiplier datapath: operands captured at start, one shift-add per cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            BUSY   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (idle && START && mul_sel) begin
            BUSY   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= DATA1;
            mplier <= DATA2;
        end else if (state == MUL_RUN) begin
            BUSY   <= !last;
            cnt    <= last ? '0 : cnt + 1'b1;
            acc    <= acc_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
`else
    assign idle    = 1'b1;
    assign mul_sel = 1'b0;
    assign mul_fin = 1'b0;
    assign mul_res = '0;
    assign BUSY    = 1'b0;
`endif
    // Single-cycle result; opcode 4 lands in the default here and is only legal via the multiplier path
    always_comb begin
        sc_res = '0;
        sc_ill = 1'b0;
        case (SELECT)
            OP_FWD:  sc_res = DATA2;
            OP_ADD:  sc_res = DATA1 + DATA2;
            OP_AND:  sc_res = DATA1 & DATA2;
            OP_OR:   sc_res = DATA1 | DATA2;
            OP_SLL:  sc_res = sh >= W_SH ? '0 : DATA1 << sh;
            OP_SRL:  sc_res = sh >= W_SH ? '0 : DATA1 >> sh;
            OP_SRA:  sc_res = sh >= W_SH ? {DATA_W{DATA1[DATA_W-1]}} : $unsigned($signed(DATA1) >>> sh);
            OP_ROR:  sc_res = DATA_W'({DATA1, DATA1} >> rot);
            default: sc_ill = 1'b1;
        endcase
    end
    // Result registers: updated together with a one-cycle DONE on every completed op
    always_ff @(posedge CLK) begin
        if (RESET) begin
            RESULT  <= '0;
            ZERO    <= 1'b1;
            DONE    <= 1'b0;
            ILLEGAL <= 1'b0;
        end else begin
            DONE <= sc_go || mul_fin;
            if (sc_go || mul_fin) begin
                RESULT  <= fin_res;
                ZERO    <= fin_res == '0;
                ILLEGAL <= !mul_fin && sc_ill;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed self-checking bench for multicycle_alu (8-bit and 16-bit instances)
module tb_multicycle_alu;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [3:0]  SELECT = '0;
    logic [7:0]  DATA1 = '0, DATA2 = '0, RESULT;
    logic        ZERO, BUSY, DONE, ILLEGAL;
    logic        start16 = 1'b0;
    logic [3:0]  select16 = '0;
    logic [15:0] a16 = '0, b16 = '0, result16;
    logic        zero16, busy16, done16, illegal16;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycles;
    int          dones;

    multicycle_alu #(.DATA_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
        .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .ZERO(ZERO),
        .BUSY(BUSY), .DONE(DONE), .ILLEGAL(ILLEGAL)
    );

    multicycle_alu #(.DATA_W(16)) dut16 (
        .CLK(CLK), .RESET(RESET), .START(start16), .SELECT(select16),
        .DATA1(a16), .DATA2(b16), .RESULT(result16), .ZERO(zero16),
        .BUSY(busy16), .DONE(done16), .ILLEGAL(illegal16)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        SELECT = sel;
        DATA1  = a;
        DATA2  = b;
        START  = 1'b1;
        @(posedge CLK); #1;
        START  = 1'b0;
    endtask

    task automatic single(input string tag, input logic [3:0] sel, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp, input logic ill);
        issue(sel, a, b);
        check({tag, "_done"}, DONE, 1);
        check({tag, "_res"}, RESULT, exp);
        check({tag, "_zero"}, ZERO, exp == 8'h00);
        check({tag, "_ill"}, ILLEGAL, ill);
        check({tag, "_busy"}, BUSY, 0);
        @(posedge CLK); #1;
        check({tag, "_pulse"}, DONE, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        START = 1'b1;
        SELECT = 4'd1;
        DATA1 = 8'h01;
        DATA2 = 8'h01;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_result", RESULT, 0);
        check("rst_zero", ZERO, 1);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_ill", ILLEGAL, 0);
        START = 1'b0;
        RESET = 1'b0;
        @(posedge CLK); #1;

        single("add_wrap", 4'd1, 8'h05, 8'hFB, 8'h00, 0);
        single("fwd", 4'd0, 8'h12, 8'h3C, 8'h3C, 0);
        single("and", 4'd2, 8'hF0, 8'h3C, 8'h30, 0);
        single("or", 4'd3, 8'hF0, 8'h0C, 8'hFC, 0);
        single("sra2", 4'd7, 8'h90, 8'd2, 8'hE4, 0);
        single("srl9", 4'd6, 8'h90, 8'd9, 8'h00, 0);
        single("sll7", 4'd5, 8'h01, 8'd7, 8'h80, 0);
        single("ror9", 4'd8, 8'h81, 8'd9, 8'hC0, 0);
        single("sra12", 4'd7, 8'h80, 8'd12, 8'hFF, 0);
        single("sll0", 4'd5, 8'hA5, 8'd0, 8'hA5, 0);
        single("ror3", 4'd8, 8'h0F, 8'd3, 8'hE1, 0);
        single("srl3", 4'd6, 8'hF0, 8'd3, 8'h1E, 0);
        single("ill_f", 4'hF, 8'h55, 8'h66, 8'h00, 1);
        single("ill_clear", 4'd1, 8'h01, 8'h02, 8'h03, 0);

        // back-to-back single-cycle ops with START held high
        SELECT = 4'd1; DATA1 = 8'h10; DATA2 = 8'h01; START = 1'b1;
        @(posedge CLK); #1;
        check("b2b_1", RESULT, 8'h11);
        DATA2 = 8'h02;
        @(posedge CLK); #1;
        START = 1'b0;
        check("b2b_2", RESULT, 8'h12);
        check("b2b_done", DONE, 1);
        @(posedge CLK); #1;

`ifdef ALU_MUL_EN
        issue(4'd4, 8'd13, 8'd11);
        check("mul_busy0", BUSY, 1);
        check("mul_done0", DONE, 0);
        SELECT = 4'd1;
        START = 1'b1;
        cycles = 0;
        while (!DONE && cycles < 20) begin
            DATA1 = 8'($urandom);
            DATA2 = 8'($urandom);
            @(posedge CLK); #1;
            cycles++;
            if (!DONE) check("mul_busy", BUSY, 1);
        end
        check("mul_cycles", cycles, 8);
        check("mul_res", RESULT, 8'h8F);
        check("mul_zero", ZERO, 0);
        check("mul_busy_end", BUSY, 0);
        check("mul_ill", ILLEGAL, 0);
        DATA1 = 8'd3;
        DATA2 = 8'd4;
        @(posedge CLK); #1;
        START = 1'b0;
        check("after_mul_done", DONE, 1);
        check("after_mul_res", RESULT, 8'h07);
        @(posedge CLK); #1;

        issue(4'd4, 8'hFF, 8'hFF);
        cycles = 0;
        while (!DONE && cycles < 20) begin
            @(posedge CLK); #1;
            cycles++;
        end
        check("mulff_cycles", cycles, 8);
        check("mulff_res", RESULT, 8'h01);
        @(posedge CLK); #1;

        issue(4'd4, 8'd13, 8'd11);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("abort_busy", BUSY, 0);
        check("abort_res", RESULT, 0);
        check("abort_zero", ZERO, 1);
        check("abort_done", DONE, 0);
        RESET = 1'b0;
        dones = 0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (DONE) dones++;
        end
        check("abort_no_done", dones, 0);
        single("abort_add", 4'd1, 8'h01, 8'h01, 8'h02, 0);

        select16 = 4'd4; a16 = 16'd300; b16 = 16'd7; start16 = 1'b1;
        @(posedge CLK); #1;
        start16 = 1'b0;
        check("mul16_busy", busy16, 1);
        cycles = 0;
        while (!done16 && cycles < 40) begin
            a16 = 16'($urandom);
            @(posedge CLK); #1;
            cycles++;
        end
        check("mul16_cycles", cycles, 16);
        check("mul16_res", result16, 16'd2100);
        check("mul16_zero", zero16, 0);
`else
        single("mul_ill", 4'd4, 8'd13, 8'd11, 8'h00, 1);
        single("abort_add", 4'd1, 8'h01, 8'h01, 8'h02, 0);
        select16 = 4'd4; a16 = 16'd300; b16 = 16'd7; start16 = 1'b1;
        @(posedge CLK); #1;
        start16 = 1'b0;
        check("mul16_done", done16, 1);
        check("mul16_ill", illegal16, 1);
        check("mul16_res", result16, 0);
        check("mul16_busy", busy16, 0);
`endif
        @(posedge CLK); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
